joy_db15_tx: RTL and testbench

- Responder end of the DB15 serial joystick link: emulates the external DB15 adapter's parallel-in/serial-out shift chain.
- Samples two pad words on the master's load strobe and shifts them out bit-serially on JOY_DATA, one bit per master JOY_CLK rising edge.
- Used as the loopback/bench partner of the DB15 receiver, and to drive a second core's user port from local pad state.
- All master-driven inputs are asynchronous to clk and are synchronised internally.

---
 rtl/joy_db15_tx.sv | 121 ++++++++++++
 tb/tb_joy_db15_tx.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/joy_db15_tx.sv
// DB15 joystick adapter emulation: parallel-in/serial-out responder.
// Ports: clk/reset, joystick1/2 pads, JOY_CLK/JOY_LOAD in, JOY_DATA + status out.
module joy_db15_tx #(
  parameter int   BITS_PER_PAD = 12,
  parameter int   SYNC_STAGES  = 2,
  parameter logic IDLE_LEVEL   = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] joystick1,
  input  logic [15:0] joystick2,
  input  logic        JOY_CLK,
  input  logic        JOY_LOAD,
  output logic        JOY_DATA,
  output logic        frame_done,
  output logic [4:0]  bit_count,
  output logic        proto_err
);

  localparam int         FRAME = 2 * BITS_PER_PAD;
  localparam logic [4:0] LAST  = 5'(FRAME - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_t;

  state_t                   state_q, state_d;
  logic [FRAME-1:0]         sr_q, sr_d;
  logic [4:0]               cnt_q, cnt_d;
  logic                     fd_q, fd_d;
  logic                     perr_q, perr_d;
  logic [SYNC_STAGES-1:0]   ld_sync_q, ld_sync_d;
  logic [SYNC_STAGES-1:0]   ck_sync_q, ck_sync_d;
  logic                     ld_dly_q, ld_dly_d;
  logic                     ck_dly_q, ck_dly_d;
  logic                     ld_s, ck_s;
  logic                     ld_fall, ck_rise;

  logic unused_pads;
  assign unused_pads = ^{joystick1[15:BITS_PER_PAD],
                         joystick2[15:BITS_PER_PAD]};

  assign ld_sync_d = {ld_sync_q[SYNC_STAGES-2:0], JOY_LOAD};
  assign ck_sync_d = {ck_sync_q[SYNC_STAGES-2:0], JOY_CLK};
  assign ld_s      = ld_sync_q[SYNC_STAGES-1];
  assign ck_s      = ck_sync_q[SYNC_STAGES-1];
  assign ld_dly_d  = ld_s;
  assign ck_dly_d  = ck_s;
  assign ld_fall   = ld_dly_q & ~ld_s;
  assign ck_rise   = ck_s & ~ck_dly_q;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    fd_d    = 1'b0;
    perr_d  = perr_q;
    // a load falling edge clears the error even if a clock edge coincides
    if (ld_fall) begin
      perr_d = 1'b0;
    end else if (ck_rise && !ld_s) begin
      perr_d = 1'b1;
    end
    // load held low overrides every state and tracks the pads
    if (!ld_s) begin
      state_d = LOAD;
      sr_d    = ~{joystick2[BITS_PER_PAD-1:0],
                  joystick1[BITS_PER_PAD-1:0]};
      cnt_d   = 5'd0;
    end else begin
      unique case (state_q)
        LOAD: state_d = SHIFT;
        SHIFT: begin
          if (ck_rise) begin
            sr_d  = {IDLE_LEVEL, sr_q[FRAME-1:1]};
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == LAST) begin
              fd_d    = 1'b1;
              state_d = DONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      sr_q      <= {FRAME{IDLE_LEVEL}};
      cnt_q     <= 5'd0;
      fd_q      <= 1'b0;
      perr_q    <= 1'b0;
      ld_sync_q <= '1;
      ck_sync_q <= '1;
      ld_dly_q  <= 1'b1;
      ck_dly_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      fd_q      <= fd_d;
      perr_q    <= perr_d;
      ld_sync_q <= ld_sync_d;
      ck_sync_q <= ck_sync_d;
      ld_dly_q  <= ld_dly_d;
      ck_dly_q  <= ck_dly_d;
    end
  end

  assign JOY_DATA   = (state_q == LOAD || state_q == SHIFT) ?
                      sr_q[0] : IDLE_LEVEL;
  assign frame_done = fd_q;
  assign bit_count  = cnt_q;
  assign proto_err  = perr_q;

endmodule

// File: tb/tb_joy_db15_tx.sv
// Scoreboard bench for joy_db15_tx.
// Driver queues expectations; a negedge monitor pops and compares.
module tb_joy_db15_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] joystick1, joystick2;
  logic        JOY_CLK, JOY_LOAD;
  logic        JOY_DATA, frame_done, proto_err;
  logic [4:0]  bit_count;

  joy_db15_tx dut (
    .clk       (clk),
    .reset     (reset),
    .joystick1 (joystick1),
    .joystick2 (joystick2),
    .JOY_CLK   (JOY_CLK),
    .JOY_LOAD  (JOY_LOAD),
    .JOY_DATA  (JOY_DATA),
    .frame_done(frame_done),
    .bit_count (bit_count),
    .proto_err (proto_err)
  );

  always #5 clk = ~clk;

  // kinds: 0 data, 1 bit_count, 2 proto_err, 3 frame_done count,
  // 4 bit_count at most, 5 bit_count at least
  typedef struct {
    int    kind;
    int    exp;
    string name;
  } chk_t;

  chk_t q[$];
  int   n_run  = 0;
  int   n_fail = 0;
  int   fd_cnt = 0;
  chk_t c;
  int   act;
  logic bad;

  always @(negedge clk) begin
    while (q.size() > 0) begin
      c = q.pop_front();
      case (c.kind)
        0: act = int'(JOY_DATA);
        2: act = int'(proto_err);
        3: act = fd_cnt;
        default: act = int'(bit_count);
      endcase
      case (c.kind)
        4: bad = (act > c.exp);
        5: bad = (act < c.exp);
        default: bad = (act != c.exp);
      endcase
      n_run++;
      if (bad) begin
        n_fail++;
        $display("FAIL %s: got %0d expected %0d (kind %0d)",
                 c.name, act, c.exp, c.kind);
      end
    end
    if (frame_done) fd_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input int k, input int e, input string n);
    chk_t t;
    t.kind = k;
    t.exp  = e;
    t.name = n;
    q.push_back(t);
  endtask

  task automatic load(input int n);
    JOY_LOAD = 1'b0;
    tick(n);
    JOY_LOAD = 1'b1;
    tick(6);
  endtask

  task automatic pulse();
    JOY_CLK = 1'b1;
    tick(8);
    JOY_CLK = 1'b0;
    tick(8);
  endtask

  // bit i is the i-th JOY_DATA value for j1=0005, j2=0800
  logic [23:0] frame_a;

  initial begin
    frame_a   = 24'h7FF_FFA;
    reset     = 1'b1;
    joystick1 = 16'h0005;
    joystick2 = 16'h0800;
    JOY_CLK   = 1'b0;
    JOY_LOAD  = 1'b1;
    tick(3);
    chk(0, 1, "rst_data");
    chk(1, 0, "rst_cnt");
    chk(2, 0, "rst_perr");
    chk(3, 0, "rst_fd");
    reset = 1'b0;
    tick(4);
    chk(0, 1, "idle_data");

    // full frame
    load(10);
    for (int i = 0; i < 24; i++) begin
      chk(0, int'(frame_a[i]), $sformatf("full_bit%0d", i));
      pulse();
    end
    chk(1, 24, "full_cnt");
    chk(3, 1, "full_fd");
    chk(0, 1, "full_idle");

    // over-clock
    load(10);
    for (int i = 0; i < 30; i++) begin
      chk(0, (i < 24) ? int'(frame_a[i]) : 1,
          $sformatf("over_bit%0d", i));
      pulse();
    end
    chk(1, 24, "over_cnt");
    chk(3, 2, "over_fd");

    // mid-frame reload
    load(10);
    for (int i = 0; i < 5; i++) begin
      chk(0, int'(frame_a[i]), $sformatf("mid_a%0d", i));
      pulse();
    end
    chk(1, 5, "mid_cnt5");
    joystick1 = 16'h0FFF;
    load(10);
    chk(1, 0, "mid_cnt0");
    for (int i = 0; i < 12; i++) begin
      chk(0, 0, $sformatf("mid_b%0d", i));
      pulse();
    end
    chk(1, 12, "mid_cnt12");
    chk(3, 2, "mid_fd");

    // clock during load
    JOY_LOAD = 1'b0;
    tick(6);
    for (int i = 0; i < 3; i++) pulse();
    chk(0, 0, "cdl_data");
    chk(1, 0, "cdl_cnt");
    chk(2, 1, "cdl_perr");
    JOY_LOAD = 1'b1;
    tick(6);
    chk(2, 1, "cdl_sticky");
    chk(0, 0, "cdl_bit0");
    load(10);
    chk(2, 0, "cdl_clear");

    // reset mid-frame
    joystick1 = 16'h0005;
    JOY_LOAD  = 1'b0;
    tick(6);
    pulse();
    JOY_LOAD = 1'b1;
    tick(6);
    for (int i = 0; i < 7; i++) pulse();
    chk(1, 7, "rmf_cnt7");
    chk(2, 1, "rmf_perr1");
    reset = 1'b1;
    tick(1);
    chk(0, 1, "rmf_data");
    chk(1, 0, "rmf_cnt");
    chk(2, 0, "rmf_perr");
    reset = 1'b0;
    tick(4);
    for (int i = 0; i < 3; i++) begin
      pulse();
      chk(0, 1, $sformatf("rmf_nold%0d", i));
    end
    chk(1, 0, "rmf_cnt_hold");

    // narrow glitch
    load(10);
    JOY_CLK = 1'b1;
    tick(1);
    JOY_CLK = 1'b0;
    tick(8);
    chk(4, 1, "glitch_cnt_max1");
    pulse();
    pulse();
    chk(4, 3, "glitch_cnt_max");
    chk(5, 2, "glitch_cnt_min");

    tick(3);
    if (q.size() != 0) begin
      n_run++;
      n_fail++;
      $display("FAIL drain: %0d left expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
